ika9958_cpu_port: RTL and testbench
===================================

Name: ika9958_cpu_port

Overview:
CPU-side port interface of the IKA9958. It decodes Z80 accesses to the four VDP ports (MODE[1:0]) and runs the two-byte register/address sequence, the palette write sequence and indirect register writes. It holds the 17-bit VRAM address counter and the read-ahead buffer, and drives the register-file write port directly upstream of the register block.

Parameters:
SYNC_STAGES, 2, CPU strobe synchroniser depth (2..3)

Ports:
i_XTAL1  in  1  master clock (21.48 MHz)
i_RST_n  in  1  async active-low reset
i_CSW_n  in  1  CPU write strobe (async to i_XTAL1)
i_CSR_n  in  1  CPU read strobe (async to i_XTAL1)
i_MODE  in  2  port select (0 VRAM data, 1 ctrl/status, 2 palette, 3 indirect)
i_CD  in  8  CPU data in
o_CD  out  8  CPU data out
o_CD_OE  out  1  data bus output enable
o_REG_WR  out  1  1-cycle register write strobe
o_REG_ADDR  out  6  register index
o_REG_DATA  out  8  register value
o_PAL_WR  out  1  1-cycle palette write strobe
o_PAL_ADDR  out  4  palette entry
o_PAL_DATA  out  9  {R[2:0],B[2:0],G[2:0]}
o_STATUS_SEL  out  4  status register index (R#15[3:0])
i_STATUS  in  8  selected status byte
o_STATUS_RD  out  1  1-cycle pulse at end of port-1 read
o_VRAM_REQ  out  1  access request, held until ack
o_VRAM_WE  out  1  1 = write
o_VRAM_ADDR  out  17  access address
o_VRAM_WDATA  out  8  write data
i_VRAM_ACK  in  1  1-cycle ack
i_VRAM_RDATA  in  8  read data, valid with ack
o_DROP  out  1  1-cycle pulse: VRAM access lost because busy

Behaviour:
- Strobe synchronisation: CSW_n and CSR_n pass through SYNC_STAGES flops (reset to 1). i_CD and i_MODE are sampled every cycle while synced CSW_n is low. The synced CSW_n rising edge commits the write. Action outputs appear in the cycle after edge detection.
- Simultaneous strobes: if both synced strobes are low, the write wins and the read is ignored (no OE, no side effects).
- Reads:
  - o_CD_OE = synced CSR_n low.
  - o_CD: port0 = read-ahead buffer; port1 = i_STATUS; ports 2/3 = 8'hFF.
  - Side effects happen on the synced CSR_n rising edge.
- Reset: all outputs 0 except o_CD = 8'hFF. addr, buffer, latch, R#14..R#17 shadows = 0. Ctrl flag and palette flag cleared.
- Port0 write: issue REQ/WE=1, ADDR = addr, WDATA = byte. Then addr <= addr+1 (17-bit, wraps 1FFFF->0). Ctrl flag cleared.
- Port0 read end: issue REQ/WE=0 at addr, then addr+1. Ctrl flag cleared. On ack, buffer <= i_VRAM_RDATA.
- Address increment happens at issue, so later address setups never disturb an in-flight access.
- Port1 write, flag=0: latch <= byte, flag <= 1.
- Port1 write, flag=1: flag <= 0, then
  - bit7=1: register write, REG_ADDR = byte[5:0], REG_DATA = latch.
  - bit7=0: addr[7:0] <= latch, addr[13:8] <= byte[5:0]. If byte[6]=0, issue a prefetch read (same as port0 read: issue at addr, then addr+1).
- Port1 read end: o_STATUS_RD pulse; ctrl flag cleared.
- Port2 write, pflag=0: platch <= byte, pflag <= 1.
- Port2 write, pflag=1: PAL_WR with ADDR = R16, DATA = {platch[6:4], platch[2:0], byte[2:0]}. Then R16 <= R16+1 (wraps 15->0), pflag <= 0.
- Port3 write: target = R17[5:0].
  - If target != 17: REG_WR with that target and the byte.
  - If target = 17: no write.
  - In both cases, if R17[7]=0, R17[5:0] <= +1 (wraps 63->0).
- Shadow update on every REG_WR, whatever the source:
  - reg 14: addr[16:14] <= data[2:0]
  - reg 15: R15
  - reg 16: R16 <= data[3:0], pflag <= 0
  - reg 17: R17
- o_STATUS_SEL = R15[3:0].
- VRAM busy (REQ high, no ack yet): any new access (port0 write/read or prefetch) is dropped. On a drop: o_DROP pulses, and addr and buffer are unchanged. Ack and a new request in the same cycle are allowed: REQ falls for one cycle at minimum before re-rising.
- An ack with REQ low is ignored.
- Reset mid-access clears REQ immediately; a later ack is ignored.

Test Plan:
- Port1 write 8'h1F then 8'h87 -> REG_WR pulse with ADDR=7, DATA=8'h1F. Flag cleared; a following 8'h22 becomes a new first byte.
- R#14=3, port1 write 8'hFF, 8'h7F, then three port0 writes AA/BB/CC -> VRAM writes at 0FFFF, 10000, 10001. addr=10002.
- Port1 write 8'h00, 8'h00 -> prefetch read at 0 (ack data 8'h5A). Port0 read returns 5A and triggers a read at 1. A port0 read while REQ is held -> o_DROP pulse, addr unchanged.
- R#16=15, port2 write 8'h70, 8'h05 -> PAL_WR ADDR=15, DATA=9'b111000101. R16 wraps to 0. Writing R#16 mid-pair resets pflag.
- R#17=8'h3F, port3 writes 11/22 -> REG_WR reg63=11, reg0=22. R#17=8'h91, port3 write -> no write, R17 stays 91.
- CSW_n and CSR_n low together on port0 -> exactly one VRAM write, o_CD_OE stays 0. Reset asserted with REQ high -> REQ=0, o_CD=FF.

Source files
------------

// File: rtl/ika9958_cpu_port.sv
// IKA9958 CPU port: synchronises Z80 strobes, decodes the four VDP ports and
// drives the register-file, palette and VRAM request interfaces.
module ika9958_cpu_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_XTAL1,
    input  logic        i_RST_n,
    input  logic        i_CSW_n,
    input  logic        i_CSR_n,
    input  logic [1:0]  i_MODE,
    input  logic [7:0]  i_CD,
    output logic [7:0]  o_CD,
    output logic        o_CD_OE,
    output logic        o_REG_WR,
    output logic [5:0]  o_REG_ADDR,
    output logic [7:0]  o_REG_DATA,
    output logic        o_PAL_WR,
    output logic [3:0]  o_PAL_ADDR,
    output logic [8:0]  o_PAL_DATA,
    output logic [3:0]  o_STATUS_SEL,
    input  logic [7:0]  i_STATUS,
    output logic        o_STATUS_RD,
    output logic        o_VRAM_REQ,
    output logic        o_VRAM_WE,
    output logic [16:0] o_VRAM_ADDR,
    output logic [7:0]  o_VRAM_WDATA,
    input  logic        i_VRAM_ACK,
    input  logic [7:0]  i_VRAM_RDATA,
    output logic        o_DROP
);

    logic [SYNC_STAGES-1:0] csw_sync_q, csr_sync_q;
    logic        wr_s, rd_s, wr_prev_q, rd_act_q, rd_blk_q, rd_blk_d, rd_act;
    logic [1:0]  wmode_q, rmode_q;
    logic [7:0]  cd_q;

    logic [16:0] addr_q, addr_d;
    logic [7:0]  buf_q, buf_d, latch_q, latch_d;
    logic        flag_q, flag_d, pflag_q, pflag_d;
    logic [5:0]  platch_q, platch_d;
    logic [3:0]  r15_q, r15_d, r16_q, r16_d;
    logic [7:0]  r17_q, r17_d;

    logic        reg_wr_q, reg_wr_d, pal_wr_q, pal_wr_d;
    logic [5:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_data_q, reg_data_d;
    logic [3:0]  pal_addr_q, pal_addr_d;
    logic [8:0]  pal_data_q, pal_data_d;
    logic        status_rd_q, status_rd_d, drop_q, drop_d;

    logic        req_q, req_d, pend_q, pend_d, we_q, we_d;
    logic [16:0] vaddr_q, vaddr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        wr_rise, rd_end, ack_v, busy, acc_go, acc_we;
    logic [16:0] acc_addr;

    assign wr_s = csw_sync_q[SYNC_STAGES-1];
    assign rd_s = csr_sync_q[SYNC_STAGES-1];

    // A read that ever overlaps a write stays dead until its strobe releases.
    assign rd_act   = ~rd_s & wr_s & ~rd_blk_q;
    assign rd_blk_d = rd_s ? 1'b0 : (rd_blk_q | ~wr_s);
    assign wr_rise  = wr_s & ~wr_prev_q;
    assign rd_end   = rd_s & rd_act_q;
    assign ack_v    = i_VRAM_ACK & req_q;
    assign busy     = (req_q & ~ack_v) | pend_q;

    always_comb begin
        addr_d      = addr_q;
        buf_d       = buf_q;
        latch_d     = latch_q;
        flag_d      = flag_q;
        pflag_d     = pflag_q;
        platch_d    = platch_q;
        r15_d       = r15_q;
        r16_d       = r16_q;
        r17_d       = r17_q;
        reg_wr_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        pal_wr_d    = 1'b0;
        pal_addr_d  = pal_addr_q;
        pal_data_d  = pal_data_q;
        status_rd_d = 1'b0;
        drop_d      = 1'b0;
        req_d       = req_q;
        pend_d      = pend_q;
        we_d        = we_q;
        vaddr_d     = vaddr_q;
        wdata_d     = wdata_q;
        acc_go      = 1'b0;
        acc_we      = 1'b0;
        acc_addr    = addr_q;

        if (pend_q) begin
            req_d  = 1'b1;
            pend_d = 1'b0;
        end
        if (ack_v) begin
            req_d = 1'b0;
            if (!we_q) buf_d = i_VRAM_RDATA;
        end

        if (wr_rise) begin
            case (wmode_q)
                2'd0: begin
                    acc_go = 1'b1;
                    acc_we = 1'b1;
                    flag_d = 1'b0;
                end
                2'd1: begin
                    if (!flag_q) begin
                        latch_d = cd_q;
                        flag_d  = 1'b1;
                    end else begin
                        flag_d = 1'b0;
                        if (cd_q[7]) begin
                            reg_wr_d   = 1'b1;
                            reg_addr_d = cd_q[5:0];
                            reg_data_d = latch_q;
                        end else begin
                            addr_d   = {addr_q[16:14], cd_q[5:0], latch_q};
                            acc_addr = addr_d;
                            acc_go   = ~cd_q[6];
                        end
                    end
                end
                2'd2: begin
                    if (!pflag_q) begin
                        platch_d = {cd_q[6:4], cd_q[2:0]};
                        pflag_d  = 1'b1;
                    end else begin
                        pal_wr_d   = 1'b1;
                        pal_addr_d = r16_q;
                        pal_data_d = {platch_q, cd_q[2:0]};
                        r16_d      = r16_q + 4'd1;
                        pflag_d    = 1'b0;
                    end
                end
                default: begin
                    if (r17_q[5:0] != 6'd17) begin
                        reg_wr_d   = 1'b1;
                        reg_addr_d = r17_q[5:0];
                        reg_data_d = cd_q;
                    end
                    if (!r17_q[7]) r17_d[5:0] = r17_q[5:0] + 6'd1;
                end
            endcase
        end else if (rd_end) begin
            case (rmode_q)
                2'd0: begin
                    acc_go = 1'b1;
                    flag_d = 1'b0;
                end
                2'd1: begin
                    status_rd_d = 1'b1;
                    flag_d      = 1'b0;
                end
                default: ;
            endcase
        end

        // Shadows track every register write, whichever port produced it.
        if (reg_wr_d) begin
            case (reg_addr_d)
                6'd14: addr_d[16:14] = reg_data_d[2:0];
                6'd15: r15_d = reg_data_d[3:0];
                6'd16: begin
                    r16_d   = reg_data_d[3:0];
                    pflag_d = 1'b0;
                end
                6'd17: r17_d = reg_data_d;
                default: ;
            endcase
        end

        // An ack in the same cycle frees the port, but REQ must drop for a cycle first.
        if (acc_go) begin
            if (busy) begin
                drop_d = 1'b1;
            end else begin
                if (ack_v) pend_d = 1'b1;
                else       req_d  = 1'b1;
                we_d    = acc_we;
                vaddr_d = acc_addr;
                if (acc_we) wdata_d = cd_q;
                addr_d  = acc_addr + 17'd1;
            end
        end
    end

    always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
        if (!i_RST_n) begin
            csw_sync_q  <= '1;
            csr_sync_q  <= '1;
            wr_prev_q   <= 1'b1;
            rd_act_q    <= 1'b0;
            rd_blk_q    <= 1'b0;
            wmode_q     <= 2'd0;
            rmode_q     <= 2'd0;
            cd_q        <= 8'd0;
            addr_q      <= 17'd0;
            buf_q       <= 8'd0;
            latch_q     <= 8'd0;
            flag_q      <= 1'b0;
            pflag_q     <= 1'b0;
            platch_q    <= 6'd0;
            r15_q       <= 4'd0;
            r16_q       <= 4'd0;
            r17_q       <= 8'd0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= 6'd0;
            reg_data_q  <= 8'd0;
            pal_wr_q    <= 1'b0;
            pal_addr_q  <= 4'd0;
            pal_data_q  <= 9'd0;
            status_rd_q <= 1'b0;
            drop_q      <= 1'b0;
            req_q       <= 1'b0;
            pend_q      <= 1'b0;
            we_q        <= 1'b0;
            vaddr_q     <= 17'd0;
            wdata_q     <= 8'd0;
        end else begin
            csw_sync_q  <= {csw_sync_q[SYNC_STAGES-2:0], i_CSW_n};
            csr_sync_q  <= {csr_sync_q[SYNC_STAGES-2:0], i_CSR_n};
            wr_prev_q   <= wr_s;
            rd_act_q    <= rd_act;
            rd_blk_q    <= rd_blk_d;
            rmode_q     <= i_MODE;
            if (!wr_s) begin
                wmode_q <= i_MODE;
                cd_q    <= i_CD;
            end
            addr_q      <= addr_d;
            buf_q       <= buf_d;
            latch_q     <= latch_d;
            flag_q      <= flag_d;
            pflag_q     <= pflag_d;
            platch_q    <= platch_d;
            r15_q       <= r15_d;
            r16_q       <= r16_d;
            r17_q       <= r17_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            pal_wr_q    <= pal_wr_d;
            pal_addr_q  <= pal_addr_d;
            pal_data_q  <= pal_data_d;
            status_rd_q <= status_rd_d;
            drop_q      <= drop_d;
            req_q       <= req_d;
            pend_q      <= pend_d;
            we_q        <= we_d;
            vaddr_q     <= vaddr_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        o_CD = 8'hFF;
        if (rd_act) begin
            case (rmode_q)
                2'd0:    o_CD = buf_q;
                2'd1:    o_CD = i_STATUS;
                default: o_CD = 8'hFF;
            endcase
        end
    end

    assign o_CD_OE      = rd_act;
    assign o_REG_WR     = reg_wr_q;
    assign o_REG_ADDR   = reg_addr_q;
    assign o_REG_DATA   = reg_data_q;
    assign o_PAL_WR     = pal_wr_q;
    assign o_PAL_ADDR   = pal_addr_q;
    assign o_PAL_DATA   = pal_data_q;
    assign o_STATUS_SEL = r15_q;
    assign o_STATUS_RD  = status_rd_q;
    assign o_VRAM_REQ   = req_q;
    assign o_VRAM_WE    = we_q;
    assign o_VRAM_ADDR  = vaddr_q;
    assign o_VRAM_WDATA = wdata_q;
    assign o_DROP       = drop_q;

endmodule

// File: tb/tb_ika9958_cpu_port.sv
// Directed bench for ika9958_cpu_port: port sequences driven through the
// async strobes, with outputs captured by negedge monitors.
module tb_ika9958_cpu_port;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        csw_n = 1'b1, csr_n = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  cd_in = 8'd0, status = 8'd0, rdata = 8'd0;
    logic        ack = 1'b0;
    logic [7:0]  cd_out;
    logic        cd_oe, reg_wr, pal_wr, status_rd, vreq, vwe, drop;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_data, vwdata;
    logic [3:0]  pal_addr, status_sel;
    logic [8:0]  pal_data;
    logic [16:0] vaddr;

    int checks = 0, failures = 0;
    int reg_cnt = 0, pal_cnt = 0, drop_cnt = 0, strd_cnt = 0, vreq_cnt = 0;
    logic [5:0]  last_ra;
    logic [7:0]  last_rd;
    logic [3:0]  last_pa;
    logic [8:0]  last_pd;
    logic        last_we, req_prev = 1'b0, ack_en = 1'b1;
    logic [16:0] last_va;
    logic [7:0]  last_wd;

    always #5 clk = ~clk;

    ika9958_cpu_port #(.SYNC_STAGES(2)) dut (
        .i_XTAL1(clk), .i_RST_n(rst_n), .i_CSW_n(csw_n), .i_CSR_n(csr_n),
        .i_MODE(mode), .i_CD(cd_in), .o_CD(cd_out), .o_CD_OE(cd_oe),
        .o_REG_WR(reg_wr), .o_REG_ADDR(reg_addr), .o_REG_DATA(reg_data),
        .o_PAL_WR(pal_wr), .o_PAL_ADDR(pal_addr), .o_PAL_DATA(pal_data),
        .o_STATUS_SEL(status_sel), .i_STATUS(status), .o_STATUS_RD(status_rd),
        .o_VRAM_REQ(vreq), .o_VRAM_WE(vwe), .o_VRAM_ADDR(vaddr),
        .o_VRAM_WDATA(vwdata), .i_VRAM_ACK(ack), .i_VRAM_RDATA(rdata),
        .o_DROP(drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [1:0] m, input logic [7:0] d);
        @(negedge clk);
        mode = m; cd_in = d; csw_n = 1'b0;
        repeat (4) @(negedge clk);
        csw_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic cpu_rd(input logic [1:0] m, input logic [7:0] exp, input string tag);
        @(negedge clk);
        mode = m; csr_n = 1'b0;
        repeat (5) @(negedge clk);
        chk(tag, {23'd0, cd_oe, cd_out}, {23'd0, 1'b1, exp});
        csr_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_ack(input logic [7:0] d);
        @(negedge clk);
        rdata = d; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Event capture.
    initial forever begin
        @(negedge clk);
        if (reg_wr) begin reg_cnt++; last_ra = reg_addr; last_rd = reg_data; end
        if (pal_wr) begin pal_cnt++; last_pa = pal_addr; last_pd = pal_data; end
        if (drop) drop_cnt++;
        if (status_rd) strd_cnt++;
        if (vreq && !req_prev) begin
            vreq_cnt++; last_we = vwe; last_va = vaddr; last_wd = vwdata;
        end
        req_prev = vreq;
    end

    // Single-cycle auto-ack responder.
    initial forever begin
        @(negedge clk);
        if (ack_en) begin
            if (ack) ack = 1'b0;
            else if (vreq) ack = 1'b1;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cd", {23'd0, cd_oe, cd_out}, {23'd0, 1'b0, 8'hFF});
        chk("rst_out", {reg_wr, pal_wr, vreq, drop, status_rd, status_sel},
            32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-byte register write, then flag restart.
        cpu_wr(2'd1, 8'h1F);
        chk("reg_first_byte", reg_cnt, 0);
        cpu_wr(2'd1, 8'h87);
        chk("reg7", {reg_cnt[7:0], 2'd0, last_ra, last_rd}, {8'd1, 2'd0, 6'd7, 8'h1F});
        cpu_wr(2'd1, 8'h22);
        cpu_wr(2'd1, 8'h8F);
        chk("reg15", {reg_cnt[7:0], 2'd0, last_ra, last_rd}, {8'd2, 2'd0, 6'd15, 8'h22});
        chk("status_sel", status_sel, 4'h2);
        status = 8'hA5;
        cpu_rd(2'd1, 8'hA5, "status_rd_data");
        chk("status_rd_pulse", strd_cnt, 1);

        // R#14 high bits and 17-bit address increment across 0FFFF.
        cpu_wr(2'd1, 8'h03); cpu_wr(2'd1, 8'h8E);
        cpu_wr(2'd1, 8'hFF); cpu_wr(2'd1, 8'h7F);
        chk("no_prefetch_b6", vreq_cnt, 0);
        cpu_wr(2'd0, 8'hAA);
        chk("vw_0ffff", {last_we, last_va, last_wd}, {6'd0, 1'b1, 17'h0FFFF, 8'hAA});
        cpu_wr(2'd0, 8'hBB);
        chk("vw_10000", {last_we, last_va, last_wd}, {6'd0, 1'b1, 17'h10000, 8'hBB});
        cpu_wr(2'd0, 8'hCC);
        chk("vw_10001", {last_we, last_va, last_wd}, {6'd0, 1'b1, 17'h10001, 8'hCC});
        cpu_wr(2'd0, 8'hDD);
        chk("vw_10002", {last_we, last_va, last_wd}, {6'd0, 1'b1, 17'h10002, 8'hDD});

        // Prefetch, read-ahead buffer and drop while busy.
        cpu_wr(2'd1, 8'h00); cpu_wr(2'd1, 8'h8E);
        ack_en = 1'b0; ack = 1'b0;
        cpu_wr(2'd1, 8'h00); cpu_wr(2'd1, 8'h00);
        chk("prefetch", {vreq_cnt[7:0], vreq, last_we, last_va}, {8'd5, 1'b1, 1'b0, 17'h0});
        pulse_ack(8'h5A);
        chk("req_fall", vreq, 1'b0);
        cpu_rd(2'd0, 8'h5A, "rd_buf_5a");
        chk("rd_issue_1", {vreq_cnt[7:0], vreq, last_we, last_va}, {8'd6, 1'b1, 1'b0, 17'h1});
        cpu_rd(2'd0, 8'h5A, "rd_while_busy");
        chk("drop", {drop_cnt[7:0], vreq_cnt[7:0]}, {8'd1, 8'd6});
        pulse_ack(8'h66);
        ack_en = 1'b1;
        cpu_wr(2'd0, 8'h12);
        chk("addr_after_drop", {last_we, last_va, last_wd}, {6'd0, 1'b1, 17'h2, 8'h12});
        cpu_rd(2'd0, 8'h66, "rd_buf_66");

        // Palette pair, R16 wrap, and R#16 write resetting the pair.
        cpu_wr(2'd1, 8'h0F); cpu_wr(2'd1, 8'h90);
        cpu_wr(2'd2, 8'h70); cpu_wr(2'd2, 8'h05);
        chk("pal15", {pal_cnt[7:0], last_pa, last_pd}, {8'd1, 4'hF, 9'b111000101});
        cpu_wr(2'd2, 8'h00); cpu_wr(2'd2, 8'h00);
        chk("pal_wrap", {pal_cnt[7:0], last_pa, last_pd}, {8'd2, 4'h0, 9'd0});
        cpu_wr(2'd2, 8'h11);
        cpu_wr(2'd1, 8'h05); cpu_wr(2'd1, 8'h90);
        cpu_wr(2'd2, 8'h77); cpu_wr(2'd2, 8'h03);
        chk("pal_pflag_rst", {pal_cnt[7:0], last_pa, last_pd}, {8'd3, 4'h5, 9'b111111011});

        // Indirect register writes.
        cpu_wr(2'd1, 8'h3F); cpu_wr(2'd1, 8'h91);
        cpu_wr(2'd3, 8'h11);
        chk("ind63", {reg_cnt[7:0], 2'd0, last_ra, last_rd}, {8'd8, 2'd0, 6'd63, 8'h11});
        cpu_wr(2'd3, 8'h22);
        chk("ind0", {reg_cnt[7:0], 2'd0, last_ra, last_rd}, {8'd9, 2'd0, 6'd0, 8'h22});
        cpu_wr(2'd1, 8'h91); cpu_wr(2'd1, 8'h91);
        chk("r17_set", {reg_cnt[7:0], 2'd0, last_ra, last_rd}, {8'd10, 2'd0, 6'd17, 8'h91});
        cpu_wr(2'd3, 8'h44);
        chk("ind17_skip", reg_cnt, 10);
        cpu_wr(2'd3, 8'h55);
        chk("r17_hold", reg_cnt, 10);

        // Simultaneous strobes: the write wins.
        @(negedge clk);
        mode = 2'd0; cd_in = 8'hEE; csw_n = 1'b0; csr_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("both_oe", cd_oe, 1'b0);
        csw_n = 1'b1; csr_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("both_write", {vreq_cnt[7:0], last_we, last_va}, {8'd9, 1'b1, 17'h4});
        chk("both_wdata", {drop_cnt[7:0], last_wd}, {8'd1, 8'hEE});

        // Reset mid-access.
        ack_en = 1'b0; ack = 1'b0;
        cpu_wr(2'd0, 8'h01);
        chk("pre_rst_req", vreq, 1'b1);
        mode = 2'd1; csr_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_cd", cd_out, 8'hA5);
        rst_n = 1'b0;
        #2;
        chk("rst_req", {vreq, cd_oe, cd_out}, {22'd0, 1'b0, 1'b0, 8'hFF});
        csr_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_ack(8'h77);
        chk("ack_ignored", vreq, 1'b0);
        cpu_rd(2'd0, 8'h00, "buf_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
